// File: rtl/vga_pkg.sv
// Framebuffer geometry, pixel format and fill-engine state encoding shared by the write path.
package vga_pkg;

  localparam int unsigned H_RES    = 800;
  localparam int unsigned V_RES    = 600;
  localparam int unsigned FB_DEPTH = H_RES * V_RES;
  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned COORD_W  = 12;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CLIP = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Exclusive end coordinate, widened by one bit so start+len cannot wrap before clamping.
  function automatic logic [COORD_W:0] clip_end(input logic [COORD_W-1:0] start,
                                                input logic [COORD_W-1:0] len,
                                                input logic [COORD_W:0]   limit);
    logic [COORD_W:0] sum;
    sum = {1'b0, start} + {1'b0, len};
    return (sum > limit) ? limit : sum;
  endfunction

endpackage

// File: rtl/fb_fill_engine.sv
// Rectangle-fill walker: clips once, then emits one raster-order pixel per pix_grant.
// Holds pix_valid with a stable address until granted; busy/done are registered.
module fb_fill_engine
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               fill_start,
  input  logic [COORD_W-1:0] fill_x0,
  input  logic [COORD_W-1:0] fill_y0,
  input  logic [COORD_W-1:0] fill_w,
  input  logic [COORD_W-1:0] fill_h,
  input  logic [DATA_W-1:0]  fill_color,
  input  logic               pix_grant,
  output logic               pix_valid,
  output logic [ADDR_W-1:0]  pix_addr,
  output logic [DATA_W-1:0]  pix_data,
  output logic               busy,
  output logic               done
);

  logic [1:0]         state_q, state_d;
  logic [COORD_W-1:0] x0_q, y0_q, w_q, h_q, x_q, y_q;
  logic [COORD_W:0]   x1_q, y1_q;
  logic [ADDR_W-1:0]  row_base_q;
  logic [DATA_W-1:0]  color_q;
  logic               degenerate, last_x, last_y;

  assign degenerate = (w_q == '0) || (h_q == '0) ||
                      (x0_q >= COORD_W'(H_RES)) || (y0_q >= COORD_W'(V_RES));
  assign last_x     = ({1'b0, x_q} == x1_q - 13'd1);
  assign last_y     = ({1'b0, y_q} == y1_q - 13'd1);

  assign pix_valid  = (state_q == RUN);
  assign pix_addr   = row_base_q + ADDR_W'(x_q);
  assign pix_data   = color_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fill_start) state_d = CLIP;
      CLIP:    state_d = degenerate ? DONE : RUN;
      RUN:     if (pix_grant && last_x && last_y) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      row_base_q <= '0;
      color_q    <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);

      if (state_q == IDLE && fill_start) begin
        x0_q    <= fill_x0;
        y0_q    <= fill_y0;
        w_q     <= fill_w;
        h_q     <= fill_h;
        color_q <= fill_color;
      end

      // The only multiply: first row base, once per fill. Later rows step by H_RES.
      if (state_q == CLIP) begin
        x1_q       <= clip_end(x0_q, w_q, 13'(H_RES));
        y1_q       <= clip_end(y0_q, h_q, 13'(V_RES));
        x_q        <= x0_q;
        y_q        <= y0_q;
        row_base_q <= ADDR_W'(y0_q) * ADDR_W'(H_RES);
      end

      if (state_q == RUN && pix_grant) begin
        if (last_x) begin
          x_q        <= x0_q;
          y_q        <= y_q + 12'd1;
          row_base_q <= row_base_q + ADDR_W'(H_RES);
        end else begin
          x_q <= x_q + 12'd1;
        end
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Owns framebuffer port A: alternating-priority arbitration between CPU beats and the fill engine.
// One registered stage to the BRAM; CPU waits on cpu_ack, fill engine stalls on pix_grant.
module fb_write_arbiter
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_data,
  output logic               cpu_ack,
  output logic               cpu_err,
  input  logic               fill_start,
  input  logic [COORD_W-1:0] fill_x0,
  input  logic [COORD_W-1:0] fill_y0,
  input  logic [COORD_W-1:0] fill_w,
  input  logic [COORD_W-1:0] fill_h,
  input  logic [DATA_W-1:0]  fill_color,
  output logic               fill_busy,
  output logic               fill_done,
  output logic               fb_ena,
  output logic               fb_wea,
  output logic [ADDR_W-1:0]  fb_addra,
  output logic [DATA_W-1:0]  fb_dina
);

  logic              pix_valid, pix_grant;
  logic [ADDR_W-1:0] pix_addr;
  logic [DATA_W-1:0] pix_data;
  logic              cpu_pend, grant_cpu, cpu_in_range;
  logic              last_grant;  // set when the CPU won the most recent conflict

  fb_fill_engine u_fill (
    .clk        (clk),
    .rst        (rst),
    .fill_start (fill_start),
    .fill_x0    (fill_x0),
    .fill_y0    (fill_y0),
    .fill_w     (fill_w),
    .fill_h     (fill_h),
    .fill_color (fill_color),
    .pix_grant  (pix_grant),
    .pix_valid  (pix_valid),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
    .busy       (fill_busy),
    .done       (fill_done)
  );

  // cpu_req is still the just-acked beat during the ack cycle, so it is masked there.
  assign cpu_pend     = cpu_req && !cpu_ack;
  assign grant_cpu    = cpu_pend && (!pix_valid || !last_grant);
  assign pix_grant    = pix_valid && !grant_cpu;
  assign cpu_in_range = (cpu_addr < ADDR_W'(FB_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fb_ena     <= 1'b0;
      fb_wea     <= 1'b0;
      fb_addra   <= '0;
      fb_dina    <= '0;
      cpu_ack    <= 1'b0;
      cpu_err    <= 1'b0;
      last_grant <= 1'b0;
    end else begin
      fb_ena  <= grant_cpu || pix_grant;
      fb_wea  <= pix_grant || (grant_cpu && cpu_in_range);
      cpu_ack <= grant_cpu;
      cpu_err <= grant_cpu && !cpu_in_range;
      if (grant_cpu) begin
        fb_addra <= cpu_addr;
        fb_dina  <= cpu_data;
      end else if (pix_grant) begin
        fb_addra <= pix_addr;
        fb_dina  <= pix_data;
      end
      if (cpu_pend && pix_valid) last_grant <= grant_cpu;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench: stimulus queues expected CPU and fill writes, a negedge monitor checks every port-A write.
module tb_fb_write_arbiter;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req, cpu_ack, cpu_err;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        fill_start, fill_busy, fill_done;
  logic [11:0] fill_x0, fill_y0, fill_w, fill_h;
  logic [7:0]  fill_color;
  logic        fb_ena, fb_wea;
  logic [18:0] fb_addra;
  logic [7:0]  fb_dina;

  typedef struct {
    logic [18:0] addr;
    logic [7:0]  data;
    logic        wea;
    logic        err;
  } wr_t;

  wr_t cpu_q[$];
  wr_t fill_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  done_cnt = 0;
  int  fill_wr_cnt = 0;
  int  fill_at_last_cpu = 0;

  fb_write_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .fill_start(fill_start), .fill_x0(fill_x0), .fill_y0(fill_y0),
    .fill_w(fill_w), .fill_h(fill_h), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .fb_ena(fb_ena), .fb_wea(fb_wea), .fb_addra(fb_addra), .fb_dina(fb_dina)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (fb_ena && cpu_ack) begin
        if (cpu_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cpu_unexpected: write at %0d with no pending beat", fb_addra);
        end else begin
          mon_e = cpu_q.pop_front();
          chk("cpu_addr", fb_addra, mon_e.addr);
          chk("cpu_data", fb_dina, mon_e.data);
          chk("cpu_wea", fb_wea, mon_e.wea);
          chk("cpu_err", cpu_err, mon_e.err);
        end
      end else if (fb_ena) begin
        fill_wr_cnt++;
        if (fill_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL fill_unexpected: write at %0d with no pending pixel", fb_addra);
        end else begin
          mon_e = fill_q.pop_front();
          chk("fill_addr", fb_addra, mon_e.addr);
          chk("fill_data", fb_dina, mon_e.data);
          chk("fill_wea", fb_wea, 1'b1);
          chk("fill_no_err", cpu_err, 1'b0);
        end
      end else begin
        chk("idle_quiet", {cpu_ack, cpu_err, fb_wea}, 3'b000);
      end
      if (fill_done) begin
        done_cnt++;
        chk("done_with_busy", fill_busy, 1'b1);
      end
    end
  end

  task automatic cpu_beat(input logic [18:0] a, input logic [7:0] d, input logic err);
    bit got = 0;
    cpu_q.push_back('{a, d, ~err, err});
    cpu_req = 1'b1; cpu_addr = a; cpu_data = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = cpu_ack;
    end
    chk("cpu_ack_seen", got, 1'b1);
  endtask

  task automatic fill(input logic [11:0] x0, input logic [11:0] y0, input logic [11:0] w,
                      input logic [11:0] h, input logic [7:0] c);
    fill_x0 = x0; fill_y0 = y0; fill_w = w; fill_h = h; fill_color = c; fill_start = 1'b1;
    @(negedge clk);
    fill_start = 1'b0;
    fill_x0 = 12'hABC; fill_y0 = 12'h123; fill_w = 12'hFFF; fill_h = 12'hFFF; fill_color = 8'h00;
    chk("busy_after_start", fill_busy, 1'b1);
  endtask

  task automatic wait_done(input int bound);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      seen = fill_done;
    end
    chk("fill_done_seen", seen, 1'b1);
    @(negedge clk);
    chk("busy_clear", fill_busy, 1'b0);
    chk("fill_q_drained", fill_q.size(), 0);
  endtask

  task automatic push_fill(input logic [18:0] a, input logic [7:0] c);
    fill_q.push_back('{a, c, 1'b1, 1'b0});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ena"}, fb_ena, 1'b0);
    chk({tag, "_wea"}, fb_wea, 1'b0);
    chk({tag, "_addra"}, fb_addra, 19'd0);
    chk({tag, "_dina"}, fb_dina, 8'd0);
    chk({tag, "_ack"}, cpu_ack, 1'b0);
    chk({tag, "_err"}, cpu_err, 1'b0);
    chk({tag, "_busy"}, fill_busy, 1'b0);
    chk({tag, "_done"}, fill_done, 1'b0);
  endtask

  initial begin
    cpu_req = 0; cpu_addr = 0; cpu_data = 0;
    fill_start = 0; fill_x0 = 0; fill_y0 = 0; fill_w = 0; fill_h = 0; fill_color = 0;

    @(negedge clk);
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", fb_ena, 1'b0);

    // CPU solo, out-of-range, and last valid word
    cpu_beat(19'd1234, 8'hE0, 1'b0); cpu_req = 0;
    repeat (2) @(negedge clk);
    chk("hold_addr", fb_addra, 19'd1234);
    chk("hold_data", fb_dina, 8'hE0);
    chk("hold_ena_low", fb_ena, 1'b0);
    cpu_beat(19'd480000, 8'h55, 1'b1); cpu_req = 0;
    @(negedge clk);
    cpu_beat(19'd479999, 8'h3C, 1'b0); cpu_req = 0;
    @(negedge clk);

    // Fill solo; a second fill_start while busy must be ignored
    push_fill(19'd1610, 8'h1C); push_fill(19'd1611, 8'h1C); push_fill(19'd1612, 8'h1C);
    push_fill(19'd2410, 8'h1C); push_fill(19'd2411, 8'h1C); push_fill(19'd2412, 8'h1C);
    fill(12'd10, 12'd2, 12'd3, 12'd2, 8'h1C);
    fill_x0 = 0; fill_y0 = 0; fill_w = 12'd50; fill_h = 12'd50; fill_start = 1'b1;
    @(negedge clk);
    fill_start = 1'b0;
    wait_done(50);

    // Clipped bottom-right corner, then degenerate rectangles
    push_fill(19'd479998, 8'hE3); push_fill(19'd479999, 8'hE3);
    fill(12'd798, 12'd599, 12'd5, 12'd5, 8'hE3);
    wait_done(50);
    fill(12'd5, 12'd5, 12'd0, 12'd4, 8'h77);
    wait_done(10);
    fill(12'd800, 12'd0, 12'd4, 12'd4, 8'h77);
    wait_done(10);

    // Contention: CPU streams back-to-back beats, fill_start lands on the first CPU grant
    for (int y = 50; y < 60; y++)
      for (int x = 100; x < 110; x++)
        push_fill(19'(y * 800 + x), 8'h92);
    fill_wr_cnt = 0;
    fork
      fill(12'd100, 12'd50, 12'd10, 12'd10, 8'h92);
      begin
        for (int i = 0; i < 30; i++) cpu_beat(19'(5000 + i), 8'(i * 7), 1'b0);
        cpu_req = 0;
        fill_at_last_cpu = fill_wr_cnt;
      end
    join
    chk("alternation_fill_count", fill_at_last_cpu, 56);
    wait_done(300);
    chk("contention_fill_total", fill_wr_cnt, 100);
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("done_count", done_cnt, 5);

    // Reset in the middle of a large fill
    for (int y = 0; y < 100; y++)
      for (int x = 0; x < 100; x++)
        push_fill(19'(y * 800 + x), 8'h11);
    fill(12'd0, 12'd0, 12'd100, 12'd100, 8'h11);
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_all_zero("async_reset");
    fill_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_write_after_reset", {fb_ena, fill_busy, fill_done}, 3'b000);
    end
    chk("no_done_after_abort", done_cnt, 5);
    cpu_beat(19'd7, 8'hAA, 1'b0); cpu_req = 0;
    repeat (2) @(negedge clk);
    chk("final_cpu_q_empty", cpu_q.size(), 0);
    chk("final_fill_q_empty", fill_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
